// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the two-port cache arbiter.
// Holds the FSM state enum, the port-index type and the default widths/timeout.
// Pure declarations: no logic, no latency, no flow control.
package cache_arb_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/cache_rr_pick.sv
// Two-way round-robin picker: on a tie grants the port that did not win last time.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module cache_rr_pick
    import cache_arb_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
    input  port_idx_t last_grant,
    output port_idx_t grant,
    output logic      grant_vld
);

    always_comb begin
        grant_vld = req0 | req1;
        grant     = PORT0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache-controller CPU port between two requesters (IDLE->BUSY->RESP); optional BUSY timeout via CACHE_ARB_TIMEOUT_EN.
// Latency: port ready 2 cycles plus controller latency after the request is seen in IDLE.
// Backpressure: requesters hold their request until their ready pulse; the controller stalls via mem_ready.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_re,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_ready,
    output logic              req0_err,
    input  logic              req1_re,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_ready,
    output logic              req1_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state, state_nxt;
    port_idx_t         grant_q, last_grant_q, pick;
    logic              pick_vld;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              re_q, we_q;
    logic              timeout_hit;
    logic              busy_done;
    logic [DATA_W-1:0] resp_dat;
    logic              sel_re, sel_we;

    cache_rr_pick u_rr_pick (
        .req0       (req0_re | req0_we),
        .req1       (req1_re | req1_we),
        .last_grant (last_grant_q),
        .grant      (pick),
        .grant_vld  (pick_vld)
    );

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (reset || state != BUSY) begin
            to_cnt <= '0;
        end else if (!mem_ready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires in the last allowed BUSY cycle; a late mem_ready still wins.
    assign timeout_hit = (state == BUSY) && !mem_ready && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (busy_done) begin
            err_q <= timeout_hit;
        end
    end

    assign req0_err = req0_ready & err_q;
    assign req1_err = req1_ready & err_q;
`else
    assign timeout_hit = 1'b0;
    assign req0_err    = 1'b0;
    assign req1_err    = 1'b0;
`endif

    assign busy_done = (state == BUSY) && (mem_ready || timeout_hit);
    assign resp_dat  = (mem_ready && re_q) ? mem_rdata : '0;
    assign sel_re    = (pick == PORT1) ? req1_re : req0_re;
    assign sel_we    = (pick == PORT1) ? req1_we : req0_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_re    = re_q & ~mem_ready;
                mem_we    = we_q & ~mem_ready;
                if (busy_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                req0_ready = (grant_q == PORT0);
                req1_ready = (grant_q == PORT1);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q      <= PORT0;
            last_grant_q <= PORT1;
            addr_q       <= '0;
            wdata_q      <= '0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            req0_rdata   <= '0;
            req1_rdata   <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant_q <= pick;
                addr_q  <= (pick == PORT1) ? req1_addr : req0_addr;
                wdata_q <= (pick == PORT1) ? req1_wdata : req0_wdata;
                we_q    <= sel_we;
                re_q    <= sel_re & ~sel_we;
            end
            if (busy_done) begin
                if (grant_q == PORT1) begin
                    req1_rdata <= resp_dat;
                end else begin
                    req0_rdata <= resp_dat;
                end
            end
            if (state == RESP) begin
                last_grant_q <= grant_q;
            end
        end
    end

endmodule
